// File: rtl/floo_route_comp_iter_pkg.sv
// Shared types and the rule-match helper for the iterative route computation stage.
package floo_route_comp_iter_pkg;

    localparam int unsigned AddrWidth  = 32;
    localparam int unsigned CoordWidth = 2;
    localparam int unsigned IdWidth    = 2 * CoordWidth;
    localparam int unsigned RouteWidth = 8;

    typedef logic [AddrWidth-1:0]  addr_t;
    // Destination ID packed as {x, y}
    typedef logic [IdWidth-1:0]    id_t;
    typedef logic [RouteWidth-1:0] route_t;

    // One address rule: bits set in mask are don't-care when comparing against addr
    typedef struct packed {
        id_t   id;
        addr_t addr;
        addr_t mask;
    } rule_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEmit = 2'd1,
        StErr  = 2'd2
    } state_e;

    // Rule hit: only bits that neither the request nor the rule mark as don't-care are compared
    function automatic logic mcast_match(addr_t addr, addr_t mask, rule_t rule);
        addr_t care;
        care = ~mask & ~rule.mask;
        return ((addr & care) == (rule.addr & care));
    endfunction

endpackage

// File: rtl/floo_route_comp_iter_match.sv
// Combinational rule-table match: request header -> match vector and destination count.
module floo_route_comp_iter_match
    import floo_route_comp_iter_pkg::*;
#(
    parameter int unsigned NumRules   = 4,
    parameter bit          ExcludeSrc = 1'b1,
    parameter int unsigned CntWidth   = $clog2(NumRules + 1)
) (
    input  addr_t                addr,
    input  addr_t                mask,
    input  id_t                  src_id,
    input  rule_t                rule_map [NumRules],
    output logic [NumRules-1:0]  match,
    output logic [CntWidth-1:0]  count
);

    logic [NumRules-1:0] hit;

    // Raw hits, with the requester itself removed when self-delivery is excluded
    always_comb begin
        hit = '0;
        for (int i = 0; i < NumRules; i++) begin
            hit[i] = mcast_match(addr, mask, rule_map[i]) &&
                     !(ExcludeSrc && (rule_map[i].id == src_id));
        end
    end

    // A unicast request resolves to the lowest matching rule only
    always_comb begin
        match = hit;
        if (mask == '0) begin
            match = '0;
            for (int i = NumRules - 1; i >= 0; i--) begin
                if (hit[i]) begin
                    match    = '0;
                    match[i] = 1'b1;
                end
            end
        end
    end

    // Number of destinations this request expands into
    always_comb begin
        count = '0;
        for (int i = 0; i < NumRules; i++) begin
            count = count + CntWidth'(match[i]);
        end
    end

endmodule

// File: rtl/floo_route_comp_iter.sv
// Iterative route computation: serialises a (multicast) request into one destination per handshake.
module floo_route_comp_iter
    import floo_route_comp_iter_pkg::*;
#(
    parameter int unsigned NumRules      = 4,
    parameter bit          UseRouteTable = 1'b0,
    parameter bit          ExcludeSrc    = 1'b1,
    parameter bit          AllowOverlap  = 1'b1,
    localparam int unsigned IdxWidth     = (NumRules > 1) ? $clog2(NumRules) : 1,
    localparam int unsigned CntWidth     = $clog2(NumRules + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  addr_t               addr_i,
    input  addr_t               mask_i,
    input  id_t                 src_id_i,
    input  rule_t               rule_map_i    [NumRules],
    input  route_t              route_table_i [NumRules],
    output logic                valid_o,
    input  logic                ready_i,
    output id_t                 id_o,
    output route_t              route_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                last_o,
    output logic                err_o,
    output logic [CntWidth-1:0] count_o
);

    state_e              state_q, state_d;
    logic [NumRules-1:0] pending_q, pending_d;
    logic [CntWidth-1:0] count_q, count_d;

    logic [NumRules-1:0] match;
    logic [CntWidth-1:0] match_cnt;
    logic [NumRules-1:0] lo_onehot;
    logic [IdxWidth-1:0] lo_idx;
    id_t                 lo_id;
    logic                single;
    logic                ready_c;
    logic                load;

    floo_route_comp_iter_match #(
        .NumRules   (NumRules),
        .ExcludeSrc (ExcludeSrc),
        .CntWidth   (CntWidth)
    ) i_match (
        .addr     (addr_i),
        .mask     (mask_i),
        .src_id   (src_id_i),
        .rule_map (rule_map_i),
        .match    (match),
        .count    (match_cnt)
    );

    // Lowest pending destination: index, one-hot and ID read live from the table
    always_comb begin
        lo_idx    = '0;
        lo_id     = '0;
        lo_onehot = '0;
        for (int i = NumRules - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lo_idx       = IdxWidth'(i);
                lo_id        = rule_map_i[i].id;
                lo_onehot    = '0;
                lo_onehot[i] = 1'b1;
            end
        end
    end

    assign single = ((pending_q & (pending_q - NumRules'(1))) == '0);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending destinations and destination count of the current request
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    // Next state: consume one destination per handshake, accept a new request when free
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        ready_c   = 1'b0;
        load      = 1'b0;
        case (state_q)
            StIdle: begin
                ready_c = 1'b1;
                load    = valid_i;
            end
            StEmit: begin
                if (ready_i) begin
                    pending_d = pending_q & ~lo_onehot;
                    if (single) begin
                        state_d = StIdle;
                        ready_c = AllowOverlap;
                        load    = AllowOverlap && valid_i;
                    end
                end
            end
            StErr: begin
                if (ready_i) begin
                    state_d = StIdle;
                    ready_c = AllowOverlap;
                    load    = AllowOverlap && valid_i;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            pending_d = match;
            count_d   = match_cnt;
            state_d   = (match != '0) ? StEmit : StErr;
        end
    end

    assign ready_o = rst_ni && ready_c;

    // Destination outputs, forced quiet while reset is held
    always_comb begin
        valid_o = 1'b0;
        err_o   = 1'b0;
        last_o  = 1'b0;
        id_o    = '0;
        idx_o   = '0;
        count_o = '0;
        if (rst_ni) begin
            case (state_q)
                StEmit: begin
                    valid_o = 1'b1;
                    last_o  = single;
                    id_o    = lo_id;
                    idx_o   = lo_idx;
                    count_o = count_q;
                end
                StErr: begin
                    valid_o = 1'b1;
                    err_o   = 1'b1;
                    last_o  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Source route by destination ID; IDs beyond the table yield an empty route
    always_comb begin
        route_o = '0;
        if (UseRouteTable) begin
            for (int i = 0; i < NumRules; i++) begin
                if (32'(id_o) == 32'(i)) begin
                    route_o = route_table_i[i];
                end
            end
        end
    end

endmodule

// File: doc/floo_route_comp_iter.md
Name: floo_route_comp_iter

Overview:
Sequential successor to the route computation stage for multicast-capable NIs.
- Accepts one request header (address, multicast mask, source ID) per valid/ready handshake.
- Matches it against an address/mask rule table and registers the match vector.
- Emits one destination (ID plus optional source route) per output handshake, in ascending rule order.
- Sits between the NI chimney header builder and the flit packer. NIs whose routers lack in-network replication use it to serialise multicast into unicasts; unicast requests use the same path.

Parameters:
- NumRules, 4, number of rules in the table (≥1)
- UseRouteTable, 1'b0, 1: route_o = route_table_i[id_o] (SourceRouting); 0: route_o = '0
- ExcludeSrc, 1'b1, 1: a rule whose id equals src_id_i is dropped from the match vector
- AllowOverlap, 1'b1, 1: ready_o also asserts during the final output handshake (combinational ready_i→ready_o path)
- id_t, logic, destination ID/coordinate type
- addr_t, logic, address/mask type
- rule_t, logic, struct {id_t id; addr_t addr; addr_t mask;}
- route_t, logic, source-route type

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  1  request header valid
- ready_o  out  1  request header accepted
- addr_i  in  addr_t  destination address
- mask_i  in  addr_t  multicast don't-care bits (0 = unicast)
- src_id_i  in  id_t  requester ID
- rule_map_i  in  NumRules×rule_t  rule table, quasi-static
- route_table_i  in  NumRules×route_t  routes indexed by id_o
- valid_o  out  1  destination valid
- ready_i  in  1  destination consumed
- id_o  out  id_t  destination ID
- route_o  out  route_t  destination route
- idx_o  out  $clog2(NumRules) bits (min 1)  matching rule index
- last_o  out  1  final destination of this request
- err_o  out  1  decode error (no match)
- count_o  out  $clog2(NumRules+1)  total destinations of the current request

Behaviour:
- Rule i matches when (addr_i & ~mask_i & ~rule.mask) == (rule.addr & ~mask_i & ~rule.mask).
- With ExcludeSrc, a rule with rule.id == src_id_i is cleared from the match vector.
- Unicast (mask_i == '0) keeps only the lowest matching index.
- FSM states: IDLE, EMIT, ERR.
- IDLE:
  - ready_o = 1; valid_o = 0.
  - On handshake, register pending = match vector, count = popcount, src, and rule outputs.
  - Next state: EMIT if pending ≠ 0, else ERR.
- EMIT:
  - valid_o = 1; idx_o = index of lowest set pending bit; id_o = rule_map_i[idx_o].id.
  - last_o = 1 when exactly one pending bit remains.
  - On ready_i, clear that pending bit. If it was the last bit, go to IDLE; with AllowOverlap and valid_i, accept the new request in the same cycle and stay in EMIT or go to ERR.
- ERR:
  - valid_o = 1, err_o = 1, last_o = 1, id_o = '0, idx_o = '0, count_o = 0.
  - On ready_i, go to IDLE, with the same overlap rule as EMIT.
- Latency: first destination is valid in the cycle after acceptance. Throughput: N destinations take N cycles; with AllowOverlap=0, add one IDLE cycle per request.
- While valid_o = 1 and ready_i = 0, all outputs stay stable (AXI-style).
- count_o holds for the whole request.
- rule_map_i changes while in EMIT are undefined; id_o and route_o are read live from the table via the registered index.
- Reset (rst_ni = 0 at a clock edge):
  - Next state IDLE; pending, count, and stored index cleared.
  - While rst_ni is low: ready_o = 0, valid_o = 0, err_o = 0, last_o = 0; id_o, idx_o, count_o = '0.
  - Reset mid-EMIT discards the remaining destinations with no further output.
- Simultaneous valid_i in EMIT with AllowOverlap=0: ready_o = 0; the request is held upstream.

Decomposition:
- floo_pkg:
  - mcast_rule_t template fields documented.
  - Function mcast_match(addr, mask, rule) returning bit.
- Sub-module floo_mcast_match (combinational): addr/mask/src/table → match vector and popcount.
- Lowest-set-bit selection uses the common_cells lzc.

Test Plan:
Table used unless noted: NumRules=4, 32-bit addresses, id = {x,y} = (0,0), (1,0), (0,1), (1,1); rule.addr = 0x0,0x1000_0000,0x2000_0000,0x3000_0000; rule.mask = 0x0FFF_FFFF.
1. Unicast: addr 0x1000_0040, mask 0 → one output, id (1,0), idx 1, last=1, count=1, one cycle after accept.
2. Multicast: addr 0x0000_0040, mask 0x3000_0000, src (2,2), ready_i toggling 1,0,1 → idx 0,1,2,3 in order; outputs stable during stalls; last only on idx 3; count=4.
3. Source exclusion: as scenario 2 with src (1,0) → idx 0,2,3; count=3.
4. No match: addr 0x4000_0000, mask 0 → single beat with err=1, last=1, id (0,0), count=0.
5. Overlap: two back-to-back unicasts with ready_i=1 → outputs in consecutive cycles, and ready_o=1 during the last beat. With AllowOverlap=0 there is a one-cycle gap.
6. Reset mid-stream: assert rst_ni low after the second beat of scenario 2 → valid_o=0 next cycle; ready_o=1 after release; the next unicast works.
